// File: rtl/led_pulse_stretcher_pkg.sv
// led_pulse_stretcher_pkg: shared state encoding and widths for the LED pulse stretcher
package led_pulse_stretcher_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_t;
  localparam int PENDING_W = 4;
endpackage

// File: rtl/led_pulse_stretcher_tick_generator.sv
// tick_generator: one-cycle tick every TICK_THRESHOLD clocks, restartable to phase zero
module tick_generator #(
  parameter int TICK_THRESHOLD = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);
  localparam int W = TICK_THRESHOLD > 1 ? $clog2(TICK_THRESHOLD) : 1;
  logic [W-1:0] count;
  assign tick = count == W'(TICK_THRESHOLD - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else count <= (restart || tick) ? '0 : count + W'(1);
endmodule

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: turns event pulses into queued LED blinks with minimum on-time and dark gap
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int TICK_THRESHOLD = 50,
  parameter int ON_TICKS       = 8,
  parameter int OFF_TICKS      = 4,
  parameter int MAX_PENDING    = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 eventIn,
  output logic                 ledOut,
  output logic                 busy,
  output logic [PENDING_W-1:0] pending,
  output logic                 overflow
);
  state_t state, nextState;
  logic eventD, tick, restart, phaseDone, accept, startBlink, incOk;
  logic [3:0] phase;
  assign accept     = enable && eventIn && !eventD;
  assign phaseDone  = tick && phase == (state == ON ? 4'(ON_TICKS - 1) : 4'(OFF_TICKS - 1));
  assign restart    = !enable || nextState != state;
  assign startBlink = nextState == ON && state != ON;
  assign incOk      = accept && (pending != PENDING_W'(MAX_PENDING) || startBlink);
  tick_generator #(.TICK_THRESHOLD(TICK_THRESHOLD)) uTick (
    .clk(clk), .reset_n(reset_n), .restart(restart), .tick(tick)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = !enable ? IDLE
              : state == IDLE ? (pending != '0 ? ON : IDLE)
              : !phaseDone ? state
              : state == ON ? OFF
              : pending != '0 ? ON : IDLE;
  always_comb begin
    ledOut = state == ON;
    busy   = state != IDLE;
  end
  // a start and an accepted event in the same cycle cancel, so the queue never wraps
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      eventD   <= 1'b0;
      phase    <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      eventD   <= eventIn;
      phase    <= restart ? '0 : phase + 4'(tick);
      pending  <= !enable ? '0 : pending + PENDING_W'(incOk) - PENDING_W'(startBlink);
      overflow <= overflow | (accept && !incOk);
    end
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher: table, directed and random checks against a blink-schedule model
module tb_led_pulse_stretcher;
  localparam int TT = 4, ONT = 2, OFFT = 1, MAXP = 2;
  localparam int ON_C = TT * ONT, OFF_C = TT * OFFT;
  typedef struct {int ev; int led; int busy; int pend;} vec_t;
  logic clk = 0, reset_n = 0, enable = 1, eventIn = 0;
  logic ledOut, busy, overflow;
  logic [3:0] pending;
  int checks = 0, errors = 0, blinks = 0;
  int mLeft, mPend, mOvf, mPrev, lastLed;
  vec_t tbl[15];
  led_pulse_stretcher #(.TICK_THRESHOLD(TT), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .eventIn(eventIn),
    .ledOut(ledOut), .busy(busy), .pending(pending), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic mReset();
    mLeft = 0; mPend = 0; mOvf = 0; mPrev = 0; lastLed = 0;
  endtask
  // model: each blink books ON_C lit cycles plus OFF_C dark cycles; queue is a plain count
  task automatic step(input logic ev, input logic en);
    int p;
    eventIn = ev; enable = en;
    @(posedge clk);
    if (!en) begin
      mLeft = 0; mPend = 0;
    end else begin
      p = mPend;
      if (mLeft > 0) mLeft--;
      if (mLeft == 0 && p > 0) begin mLeft = ON_C + OFF_C; p--; end
      if (ev && !mPrev) begin
        if (p < MAXP) p++;
        else mOvf = 1;
      end
      mPend = p;
    end
    mPrev = int'(ev);
    @(negedge clk);
    chk("led", int'(ledOut), int'(mLeft > OFF_C));
    chk("busy", int'(busy), int'(mLeft > 0));
    chk("pending", int'(pending), mPend);
    chk("overflow", int'(overflow), mOvf);
    if (ledOut && lastLed == 0) blinks++;
    lastLed = int'(ledOut);
  endtask
  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin step(1'b0, 1'b1); n++; end
    chk("idle_timeout", int'(busy), 0);
  endtask
  task automatic runTable();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].ev != 0, 1'b1);
      chk("tbl_led", int'(ledOut), tbl[i].led);
      chk("tbl_busy", int'(busy), tbl[i].busy);
      chk("tbl_pend", int'(pending), tbl[i].pend);
    end
  endtask
  initial begin
    tbl = '{'{1,0,0,1}, '{0,1,1,0}, '{0,1,1,0}, '{0,1,1,0}, '{0,1,1,0},
            '{0,1,1,0}, '{0,1,1,0}, '{0,1,1,0}, '{0,1,1,0}, '{0,0,1,0},
            '{0,0,1,0}, '{0,0,1,0}, '{0,0,1,0}, '{0,0,0,0}, '{0,0,0,0}};
    mReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_led", int'(ledOut), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset_n = 1;
    runTable();
    blinks = 0;
    step(1, 1); step(0, 1); step(1, 1); step(0, 1); step(1, 1);
    chk("burst_pend", int'(pending), 2);
    waitIdle();
    chk("burst_blinks", blinks, 3);
    chk("burst_ovf", int'(overflow), 0);
    blinks = 0;
    repeat (50) step(1, 1);
    step(0, 1);
    waitIdle();
    chk("held_blinks", blinks, 1);
    step(1, 1); step(0, 1);
    waitIdle();
    chk("rerise_blinks", blinks, 2);
    blinks = 0;
    step(1, 1); step(0, 1);
    repeat (5) begin step(1, 1); step(0, 1); end
    chk("sat_pend", int'(pending), 2);
    chk("sat_ovf", int'(overflow), 1);
    waitIdle();
    chk("sat_blinks", blinks, 3);
    step(1, 1); step(0, 1); step(1, 1);
    chk("dis_pre_pend", int'(pending), 1);
    step(1, 0);
    chk("dis_led", int'(ledOut), 0);
    chk("dis_busy", int'(busy), 0);
    chk("dis_pend", int'(pending), 0);
    step(1, 0); step(1, 0);
    blinks = 0;
    repeat (20) step(1, 1);
    chk("reen_blinks", blinks, 0);
    chk("reen_busy", int'(busy), 0);
    step(0, 1);
    step(1, 1); step(0, 1); step(0, 1); step(0, 1);
    #2 reset_n = 0;
    #1;
    chk("arst_led", int'(ledOut), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_pend", int'(pending), 0);
    chk("arst_ovf", int'(overflow), 0);
    mReset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    runTable();
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 2) == 0 ? !eventIn : eventIn), logic'($urandom_range(0, 15) != 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
